// File: rtl/tt_class_pkg.sv
// Shared types and constants for the truth-table classification blocks.
// Used by the sweep/capture stage and by the function-network blocks.
package tt_class_pkg;

  localparam int unsigned N_INPUTS = 7;
  localparam int unsigned TT_WIDTH = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } tt_state_e;

  typedef logic [N_INPUTS-1:0] minterm_t;

endpackage

// File: rtl/tt_valid_delay.sv
// PIPE_LAT-stage delay line for the {valid, index} capture tag.
// Lines the tag up with the network output; wires straight through when PIPE_LAT is 0.
module tt_valid_delay
  import tt_class_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_valid,
  input  minterm_t i_index,
  output logic     o_valid,
  output minterm_t o_index
);

  if (PIPE_LAT == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = i_clk ^ i_rst;
    assign o_valid = i_valid;
    assign o_index = i_index;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] r_valid;
    minterm_t            r_index [PIPE_LAT];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid <= '0;
        for (int s = 0; s < PIPE_LAT; s++) begin
          r_index[s] <= '0;
        end
      end else begin
        r_valid[0] <= i_valid;
        r_index[0] <= i_index;
        for (int s = 1; s < PIPE_LAT; s++) begin
          r_valid[s] <= r_valid[s-1];
          r_index[s] <= r_index[s-1];
        end
      end
    end

    assign o_valid = r_valid[PIPE_LAT-1];
    assign o_index = r_index[PIPE_LAT-1];
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives all 128 minterms into the network under test, captures its output into a
// truth table and compares that table against a reference latched at start.
module tt_sweep_capture
  import tt_class_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [TT_WIDTH-1:0] i_expected_tt,
  output logic [N_INPUTS-1:0] o_x_out,
  input  logic                i_f_in,
  output logic                o_busy,
  output logic                o_done,
  output logic [TT_WIDTH-1:0] o_tt_out,
  output logic                o_match,
  output logic [7:0]          o_mismatch_count,
  output logic [N_INPUTS-1:0] o_first_mismatch
);

  localparam minterm_t LastIdx = minterm_t'(TT_WIDTH - 1);

  tt_state_e           r_state;
  minterm_t            r_cnt;
  logic [TT_WIDTH-1:0] r_exp;
  logic [TT_WIDTH-1:0] r_tt;
  logic [7:0]          r_mm_cnt;
  minterm_t            r_first;

  logic     w_drv_valid;
  logic     w_cap_valid;
  minterm_t w_cap_idx;
  logic     w_cap_err;
  logic     w_accept;

  assign w_drv_valid = (r_state == StSweep);
  assign w_accept    = i_start && ((r_state == StIdle) || (r_state == StDone));

  tt_valid_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_drv_valid),
    .i_index (r_cnt),
    .o_valid (w_cap_valid),
    .o_index (w_cap_idx)
  );

  assign w_cap_err = w_cap_valid && (i_f_in != r_exp[w_cap_idx]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_tt     <= '0;
      r_mm_cnt <= '0;
      r_first  <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_state  <= StSweep;
            r_cnt    <= '0;
            r_exp    <= i_expected_tt;
            r_tt     <= '0;
            r_mm_cnt <= '0;
            r_first  <= '0;
          end
        end
        StSweep: begin
          // Counter parks at the last index; DRAIN keeps driving it.
          if (r_cnt == LastIdx) begin
            r_state <= (PIPE_LAT > 0) ? StDrain : StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDrain: begin
          if (w_cap_valid && (w_cap_idx == LastIdx)) begin
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase

      // The delay line is empty whenever a start is accepted, so this never races the clear.
      if (w_cap_valid) begin
        r_tt[w_cap_idx] <= i_f_in;
        if (w_cap_err) begin
          r_mm_cnt <= r_mm_cnt + 8'd1;
          if (r_mm_cnt == 8'd0) begin
            r_first <= w_cap_idx;
          end
        end
      end
    end
  end

  assign o_busy           = (r_state == StSweep) || (r_state == StDrain);
  assign o_done           = (r_state == StDone);
  assign o_x_out          = o_busy ? r_cnt : '0;
  assign o_tt_out         = r_tt;
  assign o_match          = o_done && (r_mm_cnt == 8'd0);
  assign o_mismatch_count = r_mm_cnt;
  assign o_first_mismatch = r_first;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: combinational stubs on a PIPE_LAT=0 instance
// and a 3-register OR7 stub on a PIPE_LAT=3 instance.
module tb_tt_sweep_capture;

  localparam logic [127:0] AND_TT = {1'b1, 127'b0};
  localparam logic [127:0] MAJ_TT = {16{8'hE8}};
  localparam logic [127:0] OR_TT  = {{127{1'b1}}, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // PIPE_LAT = 0 instance
  logic         rst0 = 1'b1, start0 = 1'b0, f0, busy0, done0, match0;
  logic [127:0] exp0 = '0, tt0;
  logic [6:0]   x0, first0;
  logic [7:0]   mm0;
  int           mode0 = 0;

  // PIPE_LAT = 3 instance
  logic         rst3 = 1'b1, start3 = 1'b0, f3, busy3, done3, match3;
  logic [127:0] exp3 = '0, tt3;
  logic [6:0]   x3, first3;
  logic [7:0]   mm3;
  logic         s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;

  int total = 0;
  int bad   = 0;

  always_comb begin
    f0 = 1'b0;
    if (mode0 == 0) f0 = &x0;
    else            f0 = (x0[0] & x0[1]) | (x0[0] & x0[2]) | (x0[1] & x0[2]);
  end

  always @(posedge clk) begin
    s1 <= |x3;
    s2 <= s1;
    s3 <= s2;
  end
  assign f3 = s3;

  tt_sweep_capture #(.PIPE_LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_start(start0), .i_expected_tt(exp0),
    .o_x_out(x0), .i_f_in(f0), .o_busy(busy0), .o_done(done0), .o_tt_out(tt0),
    .o_match(match0), .o_mismatch_count(mm0), .o_first_mismatch(first0)
  );

  tt_sweep_capture #(.PIPE_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_start(start3), .i_expected_tt(exp3),
    .o_x_out(x3), .i_f_in(f3), .o_busy(busy3), .o_done(done3), .o_tt_out(tt3),
    .o_match(match3), .o_mismatch_count(mm3), .o_first_mismatch(first3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Start a sweep on dut0; optionally re-pulse start and scramble expected at x0==inject_at.
  task automatic sweep0(input logic [127:0] e, input int inject_at, output int lat);
    exp0 = e;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("x_first", 128'(x0), 128'd0);
    check("busy_on", 128'(busy0), 128'd1);
    check("done_drop", 128'(done0), 128'd0);
    lat = 0;
    while (!done0 && lat < 300) begin
      if (inject_at >= 0 && busy0 && int'(x0) == inject_at) begin
        start0 = 1'b1;
        exp0   = ~e;
      end else begin
        start0 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    rst3 = 1'b0;
    check("rst_done", 128'(done0), 128'd0);
    check("rst_busy", 128'(busy0), 128'd0);
    check("rst_tt", tt0, 128'd0);
    check("rst_x", 128'(x0), 128'd0);
    check("rst_match", 128'(match0), 128'd0);

    // AND7 stub, matching table
    mode0 = 0;
    sweep0(AND_TT, -1, lat);
    check("and_lat", 128'(lat), 128'd128);
    check("and_tt", tt0, AND_TT);
    check("and_match", 128'(match0), 128'd1);
    check("and_mm", 128'(mm0), 128'd0);
    check("and_busy", 128'(busy0), 128'd0);
    check("and_x_done", 128'(x0), 128'd0);

    // MAJ3 stub, reference wrong at bit 5; started from DONE
    mode0 = 1;
    sweep0(MAJ_TT ^ (128'd1 << 5), -1, lat);
    check("maj_lat", 128'(lat), 128'd128);
    check("maj_tt", tt0, MAJ_TT);
    check("maj_match", 128'(match0), 128'd0);
    check("maj_mm", 128'(mm0), 128'd1);
    check("maj_first", 128'(first0), 128'd5);

    // Start pulse and new reference mid-sweep must be ignored
    sweep0(MAJ_TT, 40, lat);
    check("mid_lat", 128'(lat), 128'd128);
    check("mid_tt", tt0, MAJ_TT);
    check("mid_match", 128'(match0), 128'd1);
    check("mid_mm", 128'(mm0), 128'd0);

    // Reset mid-sweep
    mode0 = 0;
    exp0  = AND_TT;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (x0 != 7'd60 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach60", 128'(x0), 128'd60);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("mrst_x", 128'(x0), 128'd0);
    check("mrst_busy", 128'(busy0), 128'd0);
    check("mrst_done", 128'(done0), 128'd0);
    check("mrst_tt", tt0, 128'd0);
    check("mrst_mm", 128'(mm0), 128'd0);
    check("mrst_first", 128'(first0), 128'd0);
    sweep0(AND_TT, -1, lat);
    check("post_lat", 128'(lat), 128'd128);
    check("post_tt", tt0, AND_TT);
    check("post_match", 128'(match0), 128'd1);

    // Restart from DONE with a reference that differs everywhere
    sweep0(~AND_TT, -1, lat);
    check("inv_lat", 128'(lat), 128'd128);
    check("inv_tt", tt0, AND_TT);
    check("inv_mm", 128'(mm0), 128'd128);
    check("inv_first", 128'(first0), 128'd0);
    check("inv_match", 128'(match0), 128'd0);

    // PIPE_LAT=3 with registered OR7 stub
    exp3 = OR_TT;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    check("p3_x_first", 128'(x3), 128'd0);
    lat = 0;
    while (!done3 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("p3_lat", 128'(lat), 128'd131);
    check("p3_tt", tt3, OR_TT);
    check("p3_match", 128'(match3), 128'd1);
    check("p3_mm", 128'(mm3), 128'd0);
    check("p3_x_done", 128'(x3), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
